uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It detects the receiver's active-low, one-clock completion strobe and captures the 8-bit received byte into a power-of-two circular FIFO. Bytes are presented to the consumer through a show-ahead valid/ready read port. A sticky overflow flag records any byte lost while the FIFO was full.

## Interface
Parameters:
- DEPTH, 16: number of byte entries; must be a power of two, at least 2.
- ADDR_W, 4: log2(DEPTH); pointer width.

Ports:
- clk_input  in  1  system clock; all logic is on the rising edge.
- rst_n_input  in  1  reset; asynchronous, active-low.
- rx_data_input  in  8  received byte from the UART receiver.
- rx_complete_input  in  1  receiver completion strobe; idles high, goes low for one clock when rx_data_input is valid.
- rd_ready  in  1  consumer accepts the head byte.
- rd_valid  out  1  FIFO non-empty; rd_data holds the head byte.
- rd_data  out  8  head-of-FIFO byte (show-ahead).
- fifo_count  out  ADDR_W+1  number of stored bytes, 0..DEPTH.
- fifo_full  out  1  fifo_count == DEPTH.
- fifo_empty  out  1  fifo_count == 0.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO was full.
- overflow_clear  in  1  synchronous clear of overflow.

## Operation
- Strobe detection: register rx_complete_input into strobe_prev, which resets to 1.
  - push = !rx_complete_input && strobe_prev, a falling-edge detect.
  - A strobe held low for several cycles yields exactly one push.
  - The receiver updates on the falling clock edge, so both rx_data_input and the strobe are stable at the next rising edge.
- Storage:
  - DEPTH x 8 memory (mem).
  - Write pointer wr_ptr and read pointer rd_ptr, each ADDR_W+1 bits.
  - The extra MSB distinguishes full from empty.
- pop = rd_valid && rd_ready.
- Push with !fifo_full, or push with fifo_full && pop:
  - write mem[wr_ptr[ADDR_W-1:0]] = rx_data_input;
  - increment wr_ptr.
- Push with fifo_full && !pop:
  - byte is discarded;
  - overflow is set to 1;
  - pointers are unchanged.
- Pop: increment rd_ptr.
- Push and pop in the same cycle: fifo_count is unchanged. This applies both when full and when partially filled.
- Pop while empty cannot occur, because rd_valid is 0.
- Pointer wrap: natural modulo-2^(ADDR_W+1) wrap-around; no special case.
- fifo_count = wr_ptr - rd_ptr, in ADDR_W+1 bits, kept as a registered counter.
- overflow_clear:
  - clears overflow;
  - if a drop occurs in the same cycle, set wins and overflow stays 1.
- Reset, at any time including mid-transfer:
  - pointers and fifo_count = 0;
  - strobe_prev = 1;
  - overflow = 0.
  - Stored data is abandoned. A strobe already low when reset is released produces no push until it returns high and falls again.

## Timing
- Reset values:
  - rd_valid = 0;
  - rd_data = 8'h00;
  - fifo_count = 0;
  - fifo_full = 0;
  - fifo_empty = 1;
  - overflow = 0.
- Write latency: the byte is written at the first rising edge where the strobe is sampled low. rd_valid rises one cycle after that edge when the FIFO was empty.
- Read: rd_data is valid in the same cycle as rd_valid. On pop, the next byte appears on the following cycle, with no bubble.
- rd_data stays stable while rd_valid && !rd_ready.
- Throughput:
  - one push and one pop per clock;
  - the UART produces at most one byte per 10 bit-times, so the FIFO only fills if the consumer stalls.
- No combinational path from rd_ready to rd_valid.

## Structure
- Shared package uart_pkg:
  - UART_DATA_W = 8;
  - RX_FIFO_DEPTH_DEFAULT = 16;
  - byte typedef uart_byte_t.
- One sub-module, uart_strobe_edge: registers the strobe and emits the one-cycle push pulse. The top level is a thin wrapper around it plus the FIFO core.
- Memory is an inferred register array; no vendor RAM primitive.

## Test plan
- Reset, single byte:
  - Stimulus: after reset, strobe low for 1 cycle with data 8'hA5, rd_ready = 0.
  - Response: the next cycle shows rd_valid = 1, rd_data = 8'hA5, fifo_count = 1; pulse rd_ready to empty the FIFO.
- Fill to full:
  - Stimulus: push 16 bytes 8'h00..8'h0F with rd_ready = 0, then a 17th byte 8'hFF.
  - Response: fifo_full = 1, overflow = 1, fifo_count = 16. Draining yields 00..0F in order and never FF.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, push 8'h55 with rd_ready = 1 in the same cycle.
  - Response: fifo_count stays 16, overflow stays 0, and 8'h55 is read last.
- Long strobe:
  - Stimulus: strobe held low for 5 cycles with data 8'h3C.
  - Response: exactly one entry, fifo_count = 1.
- Wrap-around:
  - Stimulus: 40 push/pop pairs, each byte = index.
  - Response: the read sequence equals 0..39, and fifo_count never exceeds 1.
- Reset mid-operation and overflow clear:
  - Stimulus: with 7 bytes stored and overflow = 1, assert rst_n_input low asynchronously.
  - Response:
    - outputs go immediately to their reset values;
    - a strobe held low across reset release is not captured;
    - overflow_clear coinciding with a drop leaves overflow = 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the byte type used across the receive path.
package uart_pkg;
    localparam int UART_DATA_W           = 8;
    localparam int RX_FIFO_DEPTH_DEFAULT = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_strobe_edge.sv
// Turns the receiver's active-low completion strobe into a one-clock push pulse.
// Latency: combinational pulse in the first cycle the strobe is sampled low; no backpressure.
module uart_strobe_edge
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic push
);

    logic strobe_prev;
    logic armed;

    // armed stays low until the strobe is seen idle-high, so a strobe already
    // low when reset is released cannot masquerade as a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev <= 1'b1;
            armed       <= 1'b0;
        end else begin
            strobe_prev <= strobe_n;
            if (strobe_n) begin
                armed <= 1'b1;
            end
        end
    end

    assign push = !strobe_n && strobe_prev && armed;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver with a show-ahead valid/ready read port.
// Latency: byte visible one cycle after the strobe edge; a full FIFO drops bytes and sets sticky overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_input,
    input  logic              rst_n_input,
    input  uart_byte_t        rx_data_input,
    input  logic              rx_complete_input,
    input  logic              rd_ready,
    output logic              rd_valid,
    output uart_byte_t        rd_data,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    input  logic              overflow_clear
);

    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    uart_byte_t        mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count;
    logic              push;
    logic              pop;
    logic              accept;
    logic              drop;

    uart_strobe_edge u_strobe_edge (
        .clk      (clk_input),
        .rst_n    (rst_n_input),
        .strobe_n (rx_complete_input),
        .push     (push)
    );

    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign pop    = rd_valid && rd_ready;
    assign accept = push && (!fifo_full || pop);
    assign drop   = push && fifo_full && !pop;

    always_ff @(posedge clk_input or negedge rst_n_input) begin
        if (!rst_n_input) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({accept, pop})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_input) begin
        if (accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= rx_data_input;
        end
    end

    assign fifo_count = count;
    assign rd_valid   = (count != '0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    // Gate with rd_valid so the read port shows zero rather than unwritten memory.
    assign rd_data    = rd_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour plus hand sequences.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       overflow_clear;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       r;
        logic       c;
        logic       e_valid;
        logic [7:0] e_data;
        logic [4:0] e_count;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [16];

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_input         (clk),
        .rst_n_input       (rst_n),
        .rx_data_input     (rx_data),
        .rx_complete_input (rx_complete),
        .rd_ready          (rd_ready),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .overflow          (overflow),
        .overflow_clear    (overflow_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data     = b;
        rx_complete = 1'b0;
        step();
        rx_complete = 1'b1;
        step();
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rd_valid"},   32'(rd_valid),   32'd0);
        chk({tag, ".rd_data"},    32'(rd_data),    32'h00);
        chk({tag, ".fifo_count"}, 32'(fifo_count), 32'd0);
        chk({tag, ".fifo_full"},  32'(fifo_full),  32'd0);
        chk({tag, ".fifo_empty"}, 32'(fifo_empty), 32'd1);
        chk({tag, ".overflow"},   32'(overflow),   32'd0);
    endtask

    initial begin
        //          data   strb  rdy   clr   valid  data   cnt    ovf
        vecs[0]  = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
        vecs[1]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
        vecs[2]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[3]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[4]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[5]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[6]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[7]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[8]  = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[10] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0};
        vecs[11] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0};
        vecs[12] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0};
        vecs[13] = '{8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0};
        vecs[14] = '{8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0};
        vecs[15] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

        rst_n          = 1'b0;
        rx_complete    = 1'b1;
        rx_data        = 8'h00;
        rd_ready       = 1'b0;
        overflow_clear = 1'b0;
        #12;
        chk_reset_outputs("reset");
        #5;
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            rx_data        = vecs[i].d;
            rx_complete    = vecs[i].s;
            rd_ready       = vecs[i].r;
            overflow_clear = vecs[i].c;
            step();
            chk($sformatf("vec%0d.rd_valid", i),   32'(rd_valid),   32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.rd_data", i),    32'(rd_data),    32'(vecs[i].e_data));
            chk($sformatf("vec%0d.fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d.fifo_full", i),  32'(fifo_full),  32'(vecs[i].e_count == 5'd16));
            chk($sformatf("vec%0d.fifo_empty", i), 32'(fifo_empty), 32'(vecs[i].e_count == 5'd0));
            chk($sformatf("vec%0d.overflow", i),   32'(overflow),   32'(vecs[i].e_ovf));
        end
        rx_complete = 1'b1;
        rd_ready    = 1'b0;
        step();

        // Fill to full, then one extra byte is dropped.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill.count", 32'(fifo_count), 32'd16);
        chk("fill.full",  32'(fifo_full),  32'd1);
        chk("fill.ovf",   32'(overflow),   32'd0);
        push_byte(8'hFF);
        chk("drop.count", 32'(fifo_count), 32'd16);
        chk("drop.ovf",   32'(overflow),   32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.valid", i), 32'(rd_valid), 32'd1);
            chk($sformatf("drain%0d.data", i),  32'(rd_data),  32'(i));
            pop_one();
        end
        chk("drain.empty", 32'(fifo_empty), 32'd1);
        chk("drain.ovf",   32'(overflow),   32'd1);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        chk("clear.ovf", 32'(overflow), 32'd0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
        rx_data     = 8'h55;
        rx_complete = 1'b0;
        rd_ready    = 1'b1;
        step();
        rx_complete = 1'b1;
        rd_ready    = 1'b0;
        chk("pp_full.count", 32'(fifo_count), 32'd16);
        chk("pp_full.ovf",   32'(overflow),   32'd0);
        chk("pp_full.head",  32'(rd_data),    32'h81);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_drain%0d.data", i), 32'(rd_data),
                (i < 15) ? 32'(8'h81 + i) : 32'h55);
            pop_one();
        end
        chk("pp_drain.empty", 32'(fifo_empty), 32'd1);

        // Wrap-around: pointers pass the 2*DEPTH boundary.
        for (int i = 0; i < 40; i++) begin
            rx_data     = 8'(i);
            rx_complete = 1'b0;
            step();
            rx_complete = 1'b1;
            chk($sformatf("wrap%0d.data", i),  32'(rd_data),             32'(i));
            chk($sformatf("wrap%0d.cnt", i),   32'(fifo_count <= 5'd1),  32'd1);
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
            chk($sformatf("wrap%0d.cnt0", i),  32'(fifo_count),          32'd0);
        end

        // Asynchronous reset with data stored and overflow set.
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
        push_byte(8'hFF);
        for (int i = 0; i < 9; i++) pop_one();
        chk("pre_rst.count", 32'(fifo_count), 32'd7);
        chk("pre_rst.ovf",   32'(overflow),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        rx_data     = 8'h77;
        rx_complete = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("held_low.count", 32'(fifo_count), 32'd0);
        chk("held_low.valid", 32'(rd_valid),   32'd0);
        rx_complete = 1'b1;
        step();
        push_byte(8'h5A);
        chk("post_rst.count", 32'(fifo_count), 32'd1);
        chk("post_rst.data",  32'(rd_data),    32'h5A);
        pop_one();

        // Clear coinciding with a drop: the drop wins.
        for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i));
        rx_data        = 8'hEE;
        rx_complete    = 1'b0;
        overflow_clear = 1'b1;
        step();
        rx_complete    = 1'b1;
        overflow_clear = 1'b0;
        chk("clr_drop.ovf",   32'(overflow),   32'd1);
        chk("clr_drop.count", 32'(fifo_count), 32'd16);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        chk("clr_only.ovf",  32'(overflow), 32'd0);
        chk("clr_only.head", 32'(rd_data),  32'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
